// File: rtl/ambilight_pkg.sv
// Shared types, WS2812 timing constants and the ns-to-cycle helper.
package ambilight_pkg;

    localparam int unsigned T0H_NS    = 400;
    localparam int unsigned T1H_NS    = 800;
    localparam int unsigned TBIT_NS   = 1250;
    localparam int unsigned WORD_BITS = 24;

    typedef enum logic [1:0] {
        ST_GAP,
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Convert a duration in ns to clk cycles, rounded to nearest.
    function automatic int unsigned ns_to_cyc(input int unsigned clk_hz, input int unsigned ns);
        return 32'((64'(clk_hz) * 64'(ns) + 64'd500_000_000) / 64'd1_000_000_000);
    endfunction

endpackage

// File: rtl/led_data_gen_if.sv
// Word handshake between the colour source and the LED serialiser.
interface led_data_gen_if;
    import ambilight_pkg::*;

    rgb_t avg_rgb;
    logic trig;
    logic nxt;
    logic t_valid;
    logic rdy;

    modport master (output avg_rgb, output trig, input nxt, input t_valid, input rdy);
    modport slave  (input avg_rgb, input trig, output nxt, output t_valid, output rdy);

endinterface

// File: rtl/ws2812_bit_tx.sv
// Single-bit WS2812 waveform generator: high for T0H/T1H, low to T_BIT.
module ws2812_bit_tx #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_val,
    output logic done_c,
    output logic dout
);
    import ambilight_pkg::*;

    localparam int unsigned T_BIT = ns_to_cyc(CLK_HZ, TBIT_NS);
    localparam int unsigned T0H   = ns_to_cyc(CLK_HZ, T0H_NS);
    localparam int unsigned T1H   = ns_to_cyc(CLK_HZ, T1H_NS);
    localparam int unsigned CW    = $clog2(T_BIT + 1);

    logic          busy;
    logic          bit_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc_c;
    logic [CW-1:0] th_c;

    assign cnt_inc_c = cnt + CW'(1);
    assign th_c      = bit_q ? CW'(T1H) : CW'(T0H);
    // Last cycle of the bit; a restart here keeps bits back to back.
    assign done_c    = busy && (cnt == CW'(T_BIT - 1));

    // Bit timer and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            bit_q <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            bit_q <= bit_val;
            cnt   <= '0;
            dout  <= 1'b1;
        end else if (done_c) begin
            busy  <= 1'b0;
            dout  <= 1'b0;
        end else if (busy) begin
            cnt   <= cnt_inc_c;
            dout  <= (cnt_inc_c < th_c);
        end
    end

endmodule

// File: rtl/led_data_gen.sv
// WS2812 frame generator: word handshake, GRB shift and latch gap.
module led_data_gen #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned NUM_LEDS = 39,
    parameter int unsigned T_RST_NS = 80_000
) (
    input  logic          clk,
    input  logic          rst,
    led_data_gen_if.slave up,
    output logic          led_dout
);
    import ambilight_pkg::*;

    localparam int unsigned T_RST = ns_to_cyc(CLK_HZ, T_RST_NS);
    localparam int unsigned GW    = $clog2(T_RST + 1);
    localparam int unsigned LW    = $clog2(NUM_LEDS + 1);
    localparam int unsigned BW    = $clog2(WORD_BITS + 1);

    state_t               state, state_n;
    logic [GW-1:0]        gap_cnt, gap_cnt_n;
    logic [LW-1:0]        led_cnt, led_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [WORD_BITS-1:0] shreg, shreg_n;
    logic                 nxt, nxt_n;
    logic                 t_valid, t_valid_n;
    logic                 rdy, rdy_n;
    logic                 trig_m, trig_s;
    logic                 start_c;
    logic                 done_c;
    logic [LW-1:0]        led_inc_c;

    assign up.nxt     = nxt;
    assign up.t_valid = t_valid;
    assign up.rdy     = rdy;

    // State, counters, registered handshake outputs and trig synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
            led_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            nxt     <= 1'b0;
            t_valid <= 1'b0;
            rdy     <= 1'b0;
            trig_m  <= 1'b0;
            trig_s  <= 1'b0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_cnt_n;
            led_cnt <= led_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            nxt     <= nxt_n;
            t_valid <= t_valid_n;
            rdy     <= rdy_n;
            trig_m  <= up.trig;
            trig_s  <= trig_m;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        gap_cnt_n = gap_cnt;
        led_cnt_n = led_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        nxt_n     = nxt;
        t_valid_n = t_valid;
        rdy_n     = rdy;
        start_c   = 1'b0;
        led_inc_c = led_cnt + LW'(1);

        case (state)
            ST_GAP: begin
                if (gap_cnt == GW'(T_RST - 1)) begin
                    gap_cnt_n = '0;
                    led_cnt_n = '0;
                    nxt_n     = 1'b1;
                    rdy_n     = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            ST_IDLE: begin
                if (trig_s) begin
                    shreg_n   = {up.avg_rgb.g, up.avg_rgb.r, up.avg_rgb.b};
                    nxt_n     = 1'b0;
                    rdy_n     = 1'b0;
                    t_valid_n = 1'b1;
                    state_n   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // First bit launches on the same edge t_valid drops.
                if (!trig_s) begin
                    t_valid_n = 1'b0;
                    start_c   = 1'b1;
                    shreg_n   = shreg << 1;
                    bit_cnt_n = BW'(1);
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (done_c) begin
                    if (bit_cnt == BW'(WORD_BITS)) begin
                        bit_cnt_n = '0;
                        led_cnt_n = led_inc_c;
                        if (led_inc_c < LW'(NUM_LEDS)) begin
                            nxt_n   = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_GAP;
                        end
                    end else begin
                        start_c   = 1'b1;
                        shreg_n   = shreg << 1;
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_n = ST_GAP;
        endcase
    end

    ws2812_bit_tx #(
        .CLK_HZ (CLK_HZ)
    ) u_bit_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (start_c),
        .bit_val (shreg[WORD_BITS-1]),
        .done_c  (done_c),
        .dout    (led_dout)
    );

endmodule

// File: tb/tb_led_data_gen.sv
// Scoreboard bench: stimulus pushes expected GRB words, a line decoder pops them.
module tb_led_data_gen;

    localparam int unsigned NUM_LEDS = 3;
    localparam int unsigned T_BIT    = 125;
    localparam int unsigned T0H      = 40;
    localparam int unsigned T1H      = 80;
    localparam int unsigned T_RST    = 8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led_dout;

    led_data_gen_if u_if ();

    led_data_gen #(
        .CLK_HZ   (100_000_000),
        .NUM_LEDS (NUM_LEDS),
        .T_RST_NS (80_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (u_if),
        .led_dout (led_dout)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Line decoder / scoreboard monitor.
    int          hi_len, since_rise, nbits, low_run;
    logic [23:0] word, exp_w;
    logic        prev, prev_rdy;

    initial begin
        hi_len = 0; since_rise = 0; nbits = 0; low_run = 0;
        word = '0; exp_w = '0; prev = 1'b0; prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi_len = 0; since_rise = 0; nbits = 0; low_run = 0;
                word = '0; prev = 1'b0; prev_rdy = 1'b0;
            end else begin
                if (led_dout) begin
                    if (!prev) begin
                        if (nbits > 0) check("bit_period", 32'(since_rise), 32'(T_BIT));
                        since_rise = 0;
                        hi_len = 0;
                    end
                    hi_len++;
                    low_run = 0;
                end else begin
                    if (prev) begin
                        check("high_time", 32'(hi_len == int'(T0H) || hi_len == int'(T1H)), 32'(1));
                        word = {word[22:0], (hi_len == int'(T1H))};
                        nbits++;
                        if (nbits == 24) begin
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                n_errors++;
                                $display("FAIL word_unexpected: got 0x%06h, expected none", word);
                            end else begin
                                exp_w = exp_q.pop_front();
                                check("grb_word", 32'(word), 32'(exp_w));
                            end
                            nbits = 0;
                        end
                    end
                    low_run++;
                end
                since_rise++;
                if (u_if.rdy && !prev_rdy)
                    check("gap_before_rdy", 32'(low_run >= int'(T_RST)), 32'(1));
                prev     = led_dout;
                prev_rdy = u_if.rdy;
            end
        end
    end

    // Reset pulse, then the latch gap until rdy.
    task automatic reset_and_gap();
        int   n;
        logic seen;
        rst = 1'b1;
        @(negedge clk);
        check("rst_led_dout", 32'(led_dout), 32'(0));
        check("rst_nxt", 32'(u_if.nxt), 32'(0));
        check("rst_t_valid", 32'(u_if.t_valid), 32'(0));
        check("rst_rdy", 32'(u_if.rdy), 32'(0));
        @(negedge clk);
        rst  = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!u_if.rdy && n < int'(T_RST) + 100) begin
            @(negedge clk);
            n++;
            seen = seen | led_dout;
        end
        check("gap_len", 32'(n), 32'(T_RST));
        check("gap_nxt", 32'(u_if.nxt), 32'(1));
        check("gap_line_low", 32'(seen), 32'(0));
    endtask

    // One upstream word transfer with optional extended trig hold.
    task automatic send_word(input logic [23:0] rgb, input logic [23:0] expw,
                             input int hold, input logic first, input logic push);
        int   n;
        logic ok;
        n = 0;
        while (!u_if.nxt && n < 4000) begin @(negedge clk); n++; end
        check("nxt_before_word", 32'(u_if.nxt), 32'(1));
        check("rdy_in_idle", 32'(u_if.rdy), 32'(first));
        if (push) exp_q.push_back(expw);
        u_if.avg_rgb = rgb;
        u_if.trig    = 1'b1;
        n = 0;
        while (!u_if.t_valid && n < 10) begin @(negedge clk); n++; end
        check("trig_to_t_valid", 32'(n), 32'(3));
        check("nxt_low_on_capture", 32'(u_if.nxt), 32'(0));
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!u_if.t_valid || u_if.nxt || led_dout) ok = 1'b0;
        end
        check("hold_t_valid", 32'(ok), 32'(1));
        u_if.trig = 1'b0;
        n = 0;
        while (u_if.t_valid && n < 10) begin @(negedge clk); n++; end
        check("t_valid_release", 32'(n), 32'(3));
        check("nxt_low_at_release", 32'(u_if.nxt), 32'(0));
    endtask

    logic [23:0] up_words[3] = '{24'h010203, 24'h80FF7F, 24'hA5C33C};
    logic [23:0] up_exps[3]  = '{24'h020103, 24'hFF807F, 24'hC3A53C};

    initial begin
        int   n, k, caps, both, cyc;
        logic s1, s2, v1, v2, prev_tv;
        u_if.trig    = 1'b0;
        u_if.avg_rgb = '0;

        reset_and_gap();

        // Full frame of three words.
        send_word(24'h123456, 24'h341256, 0, 1'b1, 1'b1);
        send_word(24'hABCDEF, 24'hCDABEF, 0, 1'b0, 1'b1);
        send_word(24'h00FF00, 24'hFF0000, 0, 1'b0, 1'b1);
        n = 0;
        while (!u_if.rdy && n < 12000) begin @(negedge clk); n++; end
        check("frame1_rdy", 32'(u_if.rdy), 32'(1));

        // Long trig hold, then reset in bit 10 of the second word.
        send_word(24'hFF0000, 24'h00FF00, 50, 1'b1, 1'b1);
        send_word(24'h0F0F0F, 24'h000000, 0, 1'b0, 1'b0);
        repeat (9 * T_BIT + 50) @(negedge clk);
        reset_and_gap();

        // Emulated upstream with its own synchronisers.
        s1 = 1'b0; s2 = 1'b0; v1 = 1'b0; v2 = 1'b0; prev_tv = 1'b0;
        k = 0; caps = 0; both = 0; cyc = 0;
        while (cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (u_if.nxt && u_if.t_valid) both++;
            if (u_if.t_valid && !prev_tv) caps++;
            prev_tv = u_if.t_valid;
            if (k == 3 && u_if.rdy) break;
            s2 = s1; s1 = u_if.nxt;
            v2 = v1; v1 = u_if.t_valid;
            if (v2 && u_if.trig) begin
                u_if.trig = 1'b0;
            end else if (s2 && !u_if.trig && k < 3) begin
                u_if.avg_rgb = up_words[k];
                exp_q.push_back(up_exps[k]);
                u_if.trig = 1'b1;
                k++;
            end
        end
        check("frame3_done", 32'(k == 3 && u_if.rdy), 32'(1));
        check("frame3_captures", 32'(caps), 32'(NUM_LEDS));
        check("nxt_t_valid_overlap", 32'(both), 32'(0));
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_errors);
        $fatal(1);
    end

endmodule
